// File: rtl/serial_addsub_pkg.sv
// Shared types and elaboration helpers for the chunked serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    // WIDTH must be at least 2 and an exact multiple of a non-zero CHUNK.
    function automatic bit params_ok(input int unsigned width, input int unsigned chunk);
        return (chunk != 0) && (width >= 2) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Request/result bundle between a requester (master) and serial_addsub (slave).
interface serial_addsub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_addsub_fa_chunk.sv
// CHUNK-bit combinational ripple of full-adder cells.
module fa_chunk #(
    parameter int unsigned CHUNK = 1
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] s_o,
    output logic             cout_o,
    output logic             c_msb_in_o
);

    logic [CHUNK:0] c;

    // Ripple the carry through each cell, LSB first.
    always_comb begin
        c    = '0;
        s_o  = '0;
        c[0] = cin_i;
        for (int i = 0; i < int'(CHUNK); i++) begin
            s_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]  = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o     = c[CHUNK];
    assign c_msb_in_o = c[CHUNK-1];

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB chunk first.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_addsub_if.slave  bus
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (!params_ok(WIDTH, CHUNK)) begin : g_bad_params
        $error("serial_addsub: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] s_chunk;
    logic             c_next;
    logic             c_msb_in;

    fa_chunk #(
        .CHUNK (CHUNK)
    ) u_fa_chunk (
        .a_i        (a_q[CHUNK-1:0]),
        .b_i        (b_q[CHUNK-1:0]),
        .cin_i      (carry_q),
        .s_o        (s_chunk),
        .cout_o     (c_next),
        .c_msb_in_o (c_msb_in)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, operand capture/shift, and result update on the last chunk.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (bus.start) begin
                    // Subtraction is a + ~b + ~borrow_in.
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? ~bus.cin : bus.cin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = c_next;
                acc_d   = WIDTH'({s_chunk, acc_q} >> CHUNK);
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sum_d   = WIDTH'({s_chunk, acc_q} >> CHUNK);
                    cout_d  = c_next;
                    ovf_d   = c_msb_in ^ c_next;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;

endmodule
